guess_entry: RTL

Keypad front end for the number-guessing game. Collects three decimal digits from single-cycle key events, supports backspace/clear/enter editing, and on a valid enter presents the three digits with a one-cycle ready pulse. Sits directly upstream of the game controller: `oNum1/2/3` and `oNumRdy` drive its `iNum1/2/3` and `iNumRdy`. `oCount` and the buffered digits feed the on-screen entry preview.

---
 rtl/guess_entry_if.sv | 25 ++
 rtl/guess_entry.sv | 136 +++++++++++++
 2 files changed

// File: rtl/guess_entry_if.sv
// Key-event and guess/preview bundle between the keypad driver and guess_entry.
// The master drives key events; the slave (guess_entry) drives the guess and preview outputs.
interface guess_entry_if;
    logic       iKeyValid;
    logic [3:0] iKeyCode;
    logic [3:0] oNum1;
    logic [3:0] oNum2;
    logic [3:0] oNum3;
    logic       oNumRdy;
    logic [3:0] oBuf1;
    logic [3:0] oBuf2;
    logic [3:0] oBuf3;
    logic [1:0] oCount;
    logic       oErr;

    modport master (
        output iKeyValid, iKeyCode,
        input  oNum1, oNum2, oNum3, oNumRdy, oBuf1, oBuf2, oBuf3, oCount, oErr
    );

    modport slave (
        input  iKeyValid, iKeyCode,
        output oNum1, oNum2, oNum3, oNumRdy, oBuf1, oBuf2, oBuf3, oCount, oErr
    );
endinterface

// File: rtl/guess_entry.sv
// Keypad front end: collects three digits with backspace/clear/enter editing and idle timeout.
// Optional macro GUESS_ENTRY_DUP_CHECK_EN rejects guesses containing repeated digits.
module guess_entry #(
    parameter int TIMEOUT_CYCLES = 50_000_000,
    parameter int TIMEOUT_W      = 26
) (
    input  logic          clk,
    input  logic          reset_n,
    guess_entry_if.slave  bus
);

    typedef enum logic [1:0] {
        EMPTY = 2'd0,
        PART1 = 2'd1,
        PART2 = 2'd2,
        FULL  = 2'd3
    } state_e;

    localparam logic [TIMEOUT_W-1:0] IDLE_LAST = TIMEOUT_W'(TIMEOUT_CYCLES - 1);

    localparam logic [3:0] KEY_BKSP  = 4'hA;
    localparam logic [3:0] KEY_ENTER = 4'hB;
    localparam logic [3:0] KEY_CLEAR = 4'hC;

    state_e               state_q, state_d;
    logic [3:0]           buf1_q, buf1_d, buf2_q, buf2_d, buf3_q, buf3_d;
    logic [3:0]           num1_q, num1_d, num2_q, num2_d, num3_q, num3_d;
    logic                 num_rdy_q, num_rdy_d;
    logic                 err_q, err_d;
    logic [TIMEOUT_W-1:0] idle_q, idle_d;
    logic                 key_accepted;
    logic                 guess_ok;

    // Reserved codes 0xD-0xF are not accepted keys and leave everything untouched.
    assign key_accepted = bus.iKeyValid && (bus.iKeyCode <= KEY_CLEAR);

`ifdef GUESS_ENTRY_DUP_CHECK_EN
    assign guess_ok = (buf1_q != buf2_q) && (buf1_q != buf3_q) && (buf2_q != buf3_q);
`else
    assign guess_ok = 1'b1;
`endif

    always_comb begin
        state_d   = state_q;
        buf1_d    = buf1_q;
        buf2_d    = buf2_q;
        buf3_d    = buf3_q;
        num1_d    = num1_q;
        num2_d    = num2_q;
        num3_d    = num3_q;
        num_rdy_d = 1'b0;
        err_d     = 1'b0;
        idle_d    = (state_q == EMPTY) ? '0 : idle_q + TIMEOUT_W'(1);

        if (key_accepted) begin
            idle_d = '0;
            if (bus.iKeyCode <= 4'd9) begin
                unique case (state_q)
                    EMPTY: begin buf1_d = bus.iKeyCode; state_d = PART1; end
                    PART1: begin buf2_d = bus.iKeyCode; state_d = PART2; end
                    PART2: begin buf3_d = bus.iKeyCode; state_d = FULL;  end
                    FULL:  err_d = 1'b1;
                endcase
            end else if (bus.iKeyCode == KEY_BKSP) begin
                unique case (state_q)
                    EMPTY: ;
                    PART1: begin buf1_d = 4'd0; state_d = EMPTY; end
                    PART2: begin buf2_d = 4'd0; state_d = PART1; end
                    FULL:  begin buf3_d = 4'd0; state_d = PART2; end
                endcase
            end else if (bus.iKeyCode == KEY_CLEAR) begin
                buf1_d  = 4'd0;
                buf2_d  = 4'd0;
                buf3_d  = 4'd0;
                state_d = EMPTY;
            end else if (bus.iKeyCode == KEY_ENTER) begin
                if (state_q == FULL && guess_ok) begin
                    num1_d    = buf1_q;
                    num2_d    = buf2_q;
                    num3_d    = buf3_q;
                    num_rdy_d = 1'b1;
                    buf1_d    = 4'd0;
                    buf2_d    = 4'd0;
                    buf3_d    = 4'd0;
                    state_d   = EMPTY;
                end else begin
                    err_d = 1'b1;
                end
            end
        end else if (state_q != EMPTY && idle_q == IDLE_LAST) begin
            // A key in the expiry cycle takes the branch above, so expiry only fires when idle.
            buf1_d  = 4'd0;
            buf2_d  = 4'd0;
            buf3_d  = 4'd0;
            state_d = EMPTY;
            idle_d  = '0;
        end
    end

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q   <= EMPTY;
            buf1_q    <= 4'd0;
            buf2_q    <= 4'd0;
            buf3_q    <= 4'd0;
            num1_q    <= 4'd0;
            num2_q    <= 4'd0;
            num3_q    <= 4'd0;
            num_rdy_q <= 1'b0;
            err_q     <= 1'b0;
            idle_q    <= '0;
        end else begin
            state_q   <= state_d;
            buf1_q    <= buf1_d;
            buf2_q    <= buf2_d;
            buf3_q    <= buf3_d;
            num1_q    <= num1_d;
            num2_q    <= num2_d;
            num3_q    <= num3_d;
            num_rdy_q <= num_rdy_d;
            err_q     <= err_d;
            idle_q    <= idle_d;
        end
    end

    assign bus.oNum1   = num1_q;
    assign bus.oNum2   = num2_q;
    assign bus.oNum3   = num3_q;
    assign bus.oNumRdy = num_rdy_q;
    assign bus.oBuf1   = buf1_q;
    assign bus.oBuf2   = buf2_q;
    assign bus.oBuf3   = buf3_q;
    assign bus.oCount  = state_q;
    assign bus.oErr    = err_q;

endmodule
